rand_range: RTL and testbench

RAND_RANGE -- requirements
Module: rand_range

---
 rtl/rand_range.sv | 111 +++++++++++
 tb/tb_rand_range.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rand_range.sv
// Bounded random number request engine: masks draws from an upstream 8-bit
// generator down to [0..N] by rejection sampling, with a halved fallback after MAX_TRIES.
module rand_range #(
  parameter int MAX_TRIES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic [7:0] range_max,
  input  logic [7:0] rng_data,
  output logic       rng_en,
  output logic       busy,
  output logic       valid,
  input  logic       ready,
  output logic [7:0] result,
  output logic       fallback
);

  // state   | meaning
  // IDLE    | waiting for req; latches N and mask on acceptance
  // ADVANCE | steps the generator for exactly one cycle
  // CHECK   | masks the fresh draw, accepts, retries or falls back
  // DONE    | result presented until valid && ready
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ADVANCE = 2'd1,
    S_CHECK   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [3:0] LAST_TRY = 4'(MAX_TRIES - 1);

  state_t     state_q, state_d;
  logic [7:0] n_q, n_d;
  logic [7:0] mask_q, mask_d;
  logic [3:0] try_q, try_d;
  logic [7:0] result_q, result_d;
  logic       fallback_q, fallback_d;
  logic [7:0] sample;
  logic [7:0] smear;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      n_q        <= 8'h00;
      mask_q     <= 8'h00;
      try_q      <= 4'd0;
      result_q   <= 8'h00;
      fallback_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      mask_q     <= mask_d;
      try_q      <= try_d;
      result_q   <= result_d;
      fallback_q <= fallback_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    mask_d     = mask_q;
    try_d      = try_q;
    result_d   = result_q;
    fallback_d = fallback_q;
    sample     = rng_data & mask_q;
    // Smearing the top set bit downward yields the smallest 2^k-1 >= N.
    smear      = range_max | (range_max >> 1);
    smear      = smear | (smear >> 2);
    smear      = smear | (smear >> 4);

    case (state_q)
      S_IDLE: begin
        if (req) begin
          n_d     = range_max;
          mask_d  = smear;
          try_d   = 4'd0;
          state_d = S_ADVANCE;
        end
      end
      S_ADVANCE: state_d = S_CHECK;
      S_CHECK: begin
        if (sample <= n_q) begin
          result_d   = sample;
          fallback_d = 1'b0;
          state_d    = S_DONE;
        end else if (try_q < LAST_TRY) begin
          try_d   = try_q + 4'd1;
          state_d = S_ADVANCE;
        end else begin
          // A rejected sample is at most mask <= 2N-1, so halving lands below N.
          result_d   = sample >> 1;
          fallback_d = 1'b1;
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        if (ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rng_en   = (state_q == S_ADVANCE);
  assign busy     = (state_q != S_IDLE);
  assign valid    = (state_q == S_DONE);
  assign result   = result_q;
  assign fallback = fallback_q;

endmodule

// File: tb/tb_rand_range.sv
// Scoreboard bench for rand_range: two instances (MAX_TRIES 8 and 4) share stimulus,
// each with its own generator; a rule-level model predicts result, fallback, latency, draws.
module tb_rand_range;

  logic       clk = 1'b0;
  logic       reset;
  logic       req;
  logic [7:0] range_max;
  logic       ready;
  logic [1:0] rng_en, busy, valid, fallback;
  logic [7:0] result [2];
  logic [7:0] gen [2];
  logic       gen_load;
  logic [7:0] gen_val;
  bit         rand_ready;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  typedef struct {
    int res0; int res1;
    bit fb0;  bit fb1;
    int d0;   int d1;
    int acc;
  } exp_t;

  exp_t sb [$];
  int   rd [2];
  int   pulses [2];
  bit   got [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rand_range #(.MAX_TRIES(8)) u_dut0 (
    .clk(clk), .reset(reset), .req(req), .range_max(range_max),
    .rng_data(gen[0]), .rng_en(rng_en[0]), .busy(busy[0]), .valid(valid[0]),
    .ready(ready), .result(result[0]), .fallback(fallback[0])
  );

  rand_range #(.MAX_TRIES(4)) u_dut4 (
    .clk(clk), .reset(reset), .req(req), .range_max(range_max),
    .rng_data(gen[1]), .rng_en(rng_en[1]), .busy(busy[1]), .valid(valid[1]),
    .ready(ready), .result(result[1]), .fallback(fallback[1])
  );

  function automatic logic [7:0] lfsr_next(input logic [7:0] g);
    return {g[6:0], g[7] ^ g[0]};
  endfunction

  // Upstream generators: step on rng_en, loadable by the bench while the DUTs idle.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (gen_load) gen[i] <= gen_val;
      else if (rng_en[i]) gen[i] <= lfsr_next(gen[i]);
    end
  end

  // Reference: draw, mask to the smallest all-ones value covering N, accept or retry.
  function automatic void predict(input logic [7:0] g0, input int n, input int mt,
                                  output int res, output bit fb, output int d);
    logic [7:0] g;
    int mask;
    int s;
    g = g0;
    mask = 0;
    while (mask < n) mask = mask * 2 + 1;
    res = 0; fb = 1'b0; d = 0;
    for (int k = 1; k <= mt; k++) begin
      g = lfsr_next(g);
      s = int'(g) & mask;
      if (s <= n) begin
        res = s; fb = 1'b0; d = k;
        return;
      end
      if (k == mt) begin
        res = s / 2; fb = 1'b1; d = k;
      end
    end
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares each presented result against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    int   lat;
    if (!reset) begin
      sb.delete();
      for (int i = 0; i < 2; i++) begin
        rd[i] = 0; pulses[i] = 0; got[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (rng_en[i]) pulses[i]++;
        if (valid[i] && !got[i]) begin
          got[i] = 1'b1;
          if (rd[i] >= sb.size()) begin
            check($sformatf("unexpected_valid[%0d]", i), 1, 0);
          end else begin
            e = sb[rd[i]];
            rd[i]++;
            lat = cyc - e.acc;
            check($sformatf("result[%0d]", i), int'(result[i]), (i == 0) ? e.res0 : e.res1);
            check($sformatf("fallback[%0d]", i), int'(fallback[i]), (i == 0) ? int'(e.fb0) : int'(e.fb1));
            check($sformatf("latency[%0d]", i), lat, 2 * ((i == 0) ? e.d0 : e.d1));
            check($sformatf("rng_en_pulses[%0d]", i), pulses[i], (i == 0) ? e.d0 : e.d1);
            pulses[i] = 0;
          end
        end
        if (valid[i] && ready) got[i] = 1'b0;
      end
    end
  end

  task automatic load_gen(input logic [7:0] v);
    gen_val = v;
    gen_load = 1'b1;
    @(posedge clk); #1;
    gen_load = 1'b0;
  endtask

  // Waits until both DUTs are idle; meanwhile pulses req only when both are busy.
  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy != 2'b00 || valid != 2'b00) && n < 300) begin
      if (rand_ready) ready = 1'($urandom_range(0, 1));
      req = (busy == 2'b11) && ($urandom_range(0, 3) == 0);
      @(posedge clk); #1;
      n++;
    end
    req = 1'b0;
    if (n >= 300) check("idle_timeout", n, 0);
  endtask

  task automatic do_req(input int n);
    exp_t e;
    wait_idle();
    range_max = 8'(n);
    req = 1'b1;
    predict(gen[0], n, 8, e.res0, e.fb0, e.d0);
    predict(gen[1], n, 4, e.res1, e.fb1, e.d1);
    e.acc = cyc + 1;
    sb.push_back(e);
    @(posedge clk); #1;
    req = 1'b0;
    range_max = 8'($urandom);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_rng_en[%0d]", tag, i), int'(rng_en[i]), 0);
      check($sformatf("%s_busy[%0d]", tag, i), int'(busy[i]), 0);
      check($sformatf("%s_valid[%0d]", tag, i), int'(valid[i]), 0);
      check($sformatf("%s_result[%0d]", tag, i), int'(result[i]), 0);
      check($sformatf("%s_fallback[%0d]", tag, i), int'(fallback[i]), 0);
    end
  endtask

  initial begin
    logic [7:0] r0, r1;
    int n;
    reset = 1'b0; req = 1'b0; ready = 1'b1; range_max = 8'h00;
    gen_load = 1'b0; gen_val = 8'h0F; rand_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("por");
    #2 reset = 1'b1;
    @(posedge clk); #1;

    // Single accepted draw, N=15 from 0x0F.
    load_gen(8'h0F);
    do_req(15);
    // Long rejection chain, N=9 from 0x0F (fallback on the 4-try instance).
    load_gen(8'h0F);
    do_req(9);
    do_req(0);
    do_req(255);

    // Stall in DONE with ready low; req pulses must be ignored.
    wait_idle();
    ready = 1'b0;
    do_req(200);
    n = 0;
    while (valid != 2'b11 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 60) check("stall_valid_timeout", n, 0);
    r0 = result[0]; r1 = result[1];
    for (int k = 0; k < 10; k++) begin
      req = (k % 2 == 0);
      @(posedge clk); #1;
      check("stall_valid", int'(valid), 3);
      check("stall_rng_en", int'(rng_en), 0);
      check("stall_result0", int'(result[0]), int'(r0));
      check("stall_result1", int'(result[1]), int'(r1));
    end
    req = 1'b0;
    ready = 1'b1;
    @(posedge clk); #1;
    check("release_busy", int'(busy), 0);
    check("release_valid", int'(valid), 0);

    // Reset mid-request, then N=255 takes the very next generator value.
    load_gen(8'h0F);
    do_req(9);
    repeat (5) @(posedge clk);
    #3 reset = 1'b0;
    #1 check_reset_outputs("mid");
    @(negedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #1;
    do_req(255);

    // Randomized phase.
    rand_ready = 1'b1;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 4) == 0) begin
        wait_idle();
        load_gen(8'($urandom_range(1, 255)));
      end
      case ($urandom_range(0, 5))
        0: n = 0;
        1: n = 255;
        2: n = $urandom_range(1, 15);
        default: n = $urandom_range(0, 255);
      endcase
      do_req(n);
    end

    rand_ready = 1'b0;
    ready = 1'b1;
    n = 0;
    while ((rd[0] != sb.size() || rd[1] != sb.size() || busy != 2'b00) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) check("drain_timeout", n, 0);
    check("drained0", rd[0], sb.size());
    check("drained1", rd[1], sb.size());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
